breadboard_sequencer: RTL and testbench

Sequential stimulus/capture stage directly upstream of the breadboard logic block. On `start` it drives the four breadboard inputs `w`, `x`, `y`, `z` through all 16 combinations in order. It holds each vector for a programmable settle time and captures the 10 breadboard outputs. It then presents each captured row to a downstream consumer over a valid/ready handshake, and optionally folds the rows into a 16-bit signature.

---
 rtl/breadboard_sequencer.sv | 154 +++++++++++++++
 tb/tb_breadboard_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/breadboard_sequencer.sv
// ============================================================================
// Module  : breadboard_sequencer
// Purpose : Sweeps the breadboard inputs {w,x,y,z} through all 16 vectors.
//           Each vector is held for SETTLE cycles before the 10 breadboard
//           outputs are captured. Each captured row is handed downstream over
//           a valid/ready handshake.
// Option  : BB_SIGNATURE_EN - when defined, every transferred row is folded
//           into a 16-bit rotate/XOR signature. When undefined, signature
//           reads as 16'h0000.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module breadboard_sequencer #(
   parameter int unsigned SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        w,
   output logic        x,
   output logic        y,
   output logic        z,
   input  logic [9:0]  r,
   output logic        row_valid,
   input  logic        row_ready,
   output logic [3:0]  row_index,
   output logic [9:0]  row_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature
);

   // A settle time of 0 is treated as 1 so that every vector gets at least one cycle.
   localparam int unsigned S_EFF = (SETTLE < 1) ? 1 : SETTLE;
   localparam int unsigned CW    = (S_EFF > 1) ? $clog2(S_EFF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(S_EFF - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic [9:0]    data_q, data_d;
   logic [3:0]    wxyz_q, wxyz_d;
   logic          xfer;

   // State, counter, row and input-vector registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         wxyz_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         wxyz_q  <= wxyz_d;
      end
   end

   // Next-state logic: the breadboard inputs follow the row index whenever a new row begins.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      wxyz_d  = wxyz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DRIVE;
               cnt_d   = '0;
               idx_d   = 4'd0;
               wxyz_d  = 4'd0;
            end
         end
         DRIVE: begin
            if (cnt_q == CNT_LAST) begin
               data_d  = r;
               cnt_d   = '0;
               state_d = PRESENT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESENT: begin
            if (row_ready) begin
               if (idx_q == 4'hF) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  wxyz_d  = idx_q + 4'd1;
                  state_d = DRIVE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign xfer      = (state_q == PRESENT) && row_ready;
   assign row_valid = (state_q == PRESENT);
   assign busy      = (state_q == DRIVE) || (state_q == PRESENT);
   assign done      = (state_q == DONE);
   assign row_index = idx_q;
   assign row_data  = data_q;
   assign {w, x, y, z} = wxyz_q;

`ifdef BB_SIGNATURE_EN
   logic [15:0] sig_q, sig_d;

   // Signature fold: rotate left by one, then XOR in the transferred row.
   always_comb begin
      sig_d = sig_q;
      if ((state_q == IDLE) && start) begin
         sig_d = 16'h0000;
      end else if (xfer) begin
         sig_d = {sig_q[14:0], sig_q[15]} ^ {2'b00, idx_q, data_q};
      end
   end

   // Signature register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= 16'h0000;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign signature = sig_q;
`else
   logic unused_xfer;
   assign unused_xfer = xfer;
   assign signature   = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_breadboard_sequencer.sv
// ============================================================================
// Module  : tb_breadboard_sequencer
// Purpose : Directed self-checking bench for breadboard_sequencer. A breadboard
//           model drives r from {w,x,y,z}. A SETTLE=2 instance is the main
//           target. SETTLE=0 and SETTLE=1 instances share its inputs and are
//           used for the timing of the first sweep.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_breadboard_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        row_ready = 1'b1;

   logic        w, x, y, z;
   logic [9:0]  r;
   logic        row_valid, busy, done;
   logic [3:0]  row_index;
   logic [9:0]  row_data;
   logic [15:0] signature;

   logic        w0, x0, y0, z0, rv0, busy0, done0;
   logic [9:0]  r0, rd0;
   logic [3:0]  ri0;
   logic [15:0] sig0;
   logic        w1, x1, y1, z1, rv1, busy1, done1;
   logic [9:0]  r1, rd1;
   logic [3:0]  ri1;
   logic [15:0] sig1;

   int nassert = 0;
   int nfail   = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   // Breadboard model: any 10-bit function of the vector that gives 10'h25B for vector 0.
   function automatic logic [9:0] bb(input logic [3:0] v);
      return 10'h25B ^ {v[1:0], v, v};
   endfunction

   assign r  = bb({w, x, y, z});
   assign r0 = bb({w0, x0, y0, z0});
   assign r1 = bb({w1, x1, y1, z1});

   breadboard_sequencer #(.SETTLE(2)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .w(w), .x(x), .y(y), .z(z), .r(r),
      .row_valid(row_valid), .row_ready(row_ready),
      .row_index(row_index), .row_data(row_data),
      .busy(busy), .done(done), .signature(signature)
   );

   breadboard_sequencer #(.SETTLE(0)) u_dut_s0 (
      .clk(clk), .rst(rst), .start(start),
      .w(w0), .x(x0), .y(y0), .z(z0), .r(r0),
      .row_valid(rv0), .row_ready(row_ready),
      .row_index(ri0), .row_data(rd0),
      .busy(busy0), .done(done0), .signature(sig0)
   );

   breadboard_sequencer #(.SETTLE(1)) u_dut_s1 (
      .clk(clk), .rst(rst), .start(start),
      .w(w1), .x(x1), .y(y1), .z(z1), .r(r1),
      .row_valid(rv1), .row_ready(row_ready),
      .row_index(ri1), .row_data(rd1),
      .busy(busy1), .done(done1), .signature(sig1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sampling and driving happen 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [15:0] fold(input logic [15:0] s, input logic [3:0] i,
                                        input logic [9:0] d);
`ifdef BB_SIGNATURE_EN
      return {s[14:0], s[15]} ^ {2'b00, i, d};
`else
      return s & 16'h0000 & {12'h000, i} & {6'h00, d};
`endif
   endfunction

   // One full sweep on the SETTLE=2 instance with optional backpressure and busy-time start pulses.
   task automatic sweep(input int bp_row, input int bp_len, input bit pulse, input int exp_done,
                        input bit chk_fast);
      int          exp_idx = 0;
      int          bp_cnt  = 0;
      int          done_c  = -1;
      int          done0_c = -1;
      int          done1_c = -1;
      bit          sig_pend = 1'b0;
      bit          p2 = 1'b0;
      bit          p9 = 1'b0;
      logic [15:0] sig_m = 16'h0000;

      row_ready = 1'b1;
      start = 1'b1;
      cyc = 0;
      step();
      start = 1'b0;
      for (int t = 0; t < 300 && done_c < 0; t++) begin
         if (sig_pend) begin
            chk("signature", {16'h0, signature}, {16'h0, sig_m});
            sig_pend = 1'b0;
         end
         if (done0 && done0_c < 0) done0_c = cyc;
         if (done1 && done1_c < 0) done1_c = cyc;
         if (done) done_c = cyc;
         start = 1'b0;
         if (busy && !row_valid) begin
            chk("wxyz_drive", {28'h0, w, x, y, z}, exp_idx[31:0]);
            if (pulse && exp_idx == 2 && !p2) begin start = 1'b1; p2 = 1'b1; end
            if (pulse && exp_idx == 9 && !p9) begin start = 1'b1; p9 = 1'b1; end
         end
         if (row_valid) begin
            if (exp_idx == bp_row && bp_cnt < bp_len) begin
               row_ready = 1'b0;
               bp_cnt++;
               chk("bp_index", {28'h0, row_index}, exp_idx[31:0]);
               chk("bp_data", {22'h0, row_data}, {22'h0, bb(exp_idx[3:0])});
            end else begin
               row_ready = 1'b1;
               chk("row_index", {28'h0, row_index}, exp_idx[31:0]);
               chk("row_data", {22'h0, row_data}, {22'h0, bb(exp_idx[3:0])});
               sig_m = fold(sig_m, exp_idx[3:0], bb(exp_idx[3:0]));
               sig_pend = 1'b1;
               exp_idx++;
            end
         end else begin
            row_ready = 1'b1;
         end
         if (done_c < 0) step();
      end
      start = 1'b0;
      row_ready = 1'b1;
      chk("done_cycle", done_c, exp_done);
      chk("rows_seen", exp_idx, 16);
      chk("sig_final", {16'h0, signature}, {16'h0, sig_m});
      if (chk_fast) begin
         chk("done_cycle_s0", done0_c, 33);
         chk("done_cycle_s1", done1_c, 33);
      end
      step();
      chk("done_pulse_end", {31'h0, done}, 32'h0);
      chk("busy_after", {31'h0, busy}, 32'h0);
      chk("idx_hold", {28'h0, row_index}, 32'hF);
      chk("data_hold", {22'h0, row_data}, {22'h0, bb(4'hF)});
      chk("wxyz_hold", {28'h0, w, x, y, z}, 32'hF);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wxyz"}, {28'h0, w, x, y, z}, 32'h0);
      chk({tag, "_valid"}, {31'h0, row_valid}, 32'h0);
      chk({tag, "_index"}, {28'h0, row_index}, 32'h0);
      chk({tag, "_data"}, {22'h0, row_data}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_done"}, {31'h0, done}, 32'h0);
      chk({tag, "_sig"}, {16'h0, signature}, 32'h0);
   endtask

   initial begin
      int guard;
      // Power-on reset.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk_zero("reset");
      step();
      chk_zero("idle");

      // Plain sweep: all three settle builds checked for done timing.
      sweep(-1, 0, 1'b0, 49, 1'b1);

      // Backpressure on row 3 for 5 cycles.
      sweep(3, 5, 1'b0, 54, 1'b0);

      // Start pulses while busy at rows 2 and 9.
      sweep(-1, 0, 1'b1, 49, 1'b0);

      // Reset in the middle of the sweep at row 5, with start held high to confirm reset wins.
      start = 1'b1;
      step();
      start = 1'b0;
      guard = 0;
      while (!(busy && !row_valid && row_index == 4'd5) && guard < 200) begin
         step();
         guard++;
      end
      chk("reach_row5", {28'h0, row_index}, 32'h5);
      rst = 1'b1;
      start = 1'b1;
      step();
      step();
      rst = 1'b0;
      start = 1'b0;
      chk_zero("midreset");
      step();
      chk("midreset_idle", {31'h0, busy}, 32'h0);

      // A fresh start after the reset begins again at row 0.
      sweep(-1, 0, 1'b0, 49, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule

`default_nettype wire
